// File: rtl/switch_debounce.sv
// switch_debounce
//   Input-conditioning stage for the slide switches/keys ahead of the PIO.
//   Each raw pin level is brought into the clk domain through a 2-flop
//   synchroniser, then filtered so that db_out only follows the synchronised
//   level after it has disagreed with db_out for STABLE_CYCLES consecutive
//   edges. One-cycle registered strobes mark every debounced 0->1 and 1->0
//   transition. Bits are fully independent.
//
//   STABLE_CYCLES must be >= 2. CNT_W is derived from it and is not meant to
//   be overridden.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset (clears all state)
//   sw_in       raw asynchronous switch/key levels
//   db_out      debounced levels, feeds the PIO in_port
//   rise_pulse  one-cycle strobe per bit when db_out goes 0->1
//   fall_pulse  one-cycle strobe per bit when db_out goes 1->0
module switch_debounce #(
    parameter int WIDTH         = 10,
    parameter int STABLE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] sync_1_q, sync_1_d;
    logic [WIDTH-1:0] sync_2_q, sync_2_d;
    logic [WIDTH-1:0] db_q,     db_d;
    logic [WIDTH-1:0] rise_q,   rise_d;
    logic [WIDTH-1:0] fall_q,   fall_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        // Plain synchroniser chain: nothing may sit between the two stages.
        sync_1_d = sw_in;
        sync_2_d = sync_1_q;
        db_d     = db_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_2_q[i] != db_q[i]) begin
                // Counter tops out at STABLE_CYCLES-1; reaching it with the
                // input still disagreeing commits the new level.
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i]   = sync_2_q[i];
                    rise_d[i] = sync_2_q[i];
                    fall_d[i] = ~sync_2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1_q <= '0;
            sync_2_q <= '0;
            db_q     <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync_1_q <= sync_1_d;
            sync_2_q <= sync_2_d;
            db_q     <= db_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign db_out     = db_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce
//   Directed stimulus for switch_debounce with STABLE_CYCLES=4, WIDTH=10.
//   Each stimulus step that should eventually move db_out pushes the expected
//   edge number and output values into a queue; a negedge monitor pops an
//   entry whenever any pulse is presented and compares it.
module tb_switch_debounce;

    localparam int W   = 10;
    localparam int SC  = 4;
    localparam int LAT = SC + 2;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] sw_in = '0;
    logic [W-1:0] db_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;

    switch_debounce #(
        .WIDTH        (W),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_in     (sw_in),
        .db_out    (db_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        name;
        int           at;
        logic [W-1:0] db;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input string name, input int at, input logic [W-1:0] db,
                        input logic [W-1:0] r, input logic [W-1:0] f);
        exp_t e;
        e.name = name;
        e.at   = at;
        e.db   = db;
        e.rise = r;
        e.fall = f;
        sb.push_back(e);
    endtask

    task automatic set_sw(input logic [W-1:0] v);
        @(negedge clk);
        sw_in = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: any pulse activity must match the oldest pending expectation.
    always @(negedge clk) begin
        if (mon_en && ((rise_pulse | fall_pulse) != '0)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got rise=0x%0h fall=0x%0h db=0x%0h expected no pulse (edge %0d)",
                         rise_pulse, fall_pulse, db_out, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_edge"}, cyc, e.at);
                chk({e.name, "_db"},   int'(db_out),     int'(e.db));
                chk({e.name, "_rise"}, int'(rise_pulse), int'(e.rise));
                chk({e.name, "_fall"}, int'(fall_pulse), int'(e.fall));
                chk({e.name, "_excl"}, int'(rise_pulse & fall_pulse), 0);
            end
        end
    end

    initial begin
        int t;
        logic bounce [6];
        bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // 1: reset held with all switches high, then power-up rise.
        reset = 1'b1;
        sw_in = '1;
        repeat (3) begin
            @(negedge clk);
            chk("t1_rst_db",   int'(db_out),     0);
            chk("t1_rst_rise", int'(rise_pulse), 0);
            chk("t1_rst_fall", int'(fall_pulse), 0);
        end
        mon_en = 1'b1;
        reset  = 1'b0;
        push("t1_powerup", cyc + LAT, 10'h3FF, 10'h3FF, 10'h000);
        idle(10);

        // Bring everything back low before the single-bit tests.
        set_sw(10'h000);
        push("t1_clear", cyc + LAT, 10'h000, 10'h000, 10'h3FF);
        idle(10);

        // 2: clean step on bit 0 up and back down.
        set_sw(10'h001);
        push("t2_rise", cyc + LAT, 10'h001, 10'h001, 10'h000);
        idle(10);
        set_sw(10'h000);
        push("t2_fall", cyc + LAT, 10'h000, 10'h000, 10'h001);
        idle(10);

        // 3: bounce on bit 3, then held high.
        for (int i = 0; i < 6; i++) begin
            set_sw(bounce[i] ? 10'h008 : 10'h000);
            chk("t3_bounce_db", int'(db_out), 0);
        end
        push("t3_settle", cyc + LAT, 10'h008, 10'h008, 10'h000);
        idle(10);

        // 4: raise bit 5, then bits 2 and 7 rise while bit 5 falls.
        set_sw(10'h028);
        push("t4_pre", cyc + LAT, 10'h028, 10'h020, 10'h000);
        idle(10);
        set_sw(10'h08C);
        push("t4_multi", cyc + LAT, 10'h08C, 10'h084, 10'h020);
        idle(10);

        // 5: bit 1 rises; one-cycle reset lands when its count has reached 2.
        set_sw(10'h08E);
        t = cyc;
        idle(4);
        chk("t5_pre_rst_edge", cyc, t + 4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_rst_db",   int'(db_out),     0);
        chk("t5_rst_rise", int'(rise_pulse), 0);
        chk("t5_rst_fall", int'(fall_pulse), 0);
        push("t5_restart", cyc + LAT, 10'h08E, 10'h08E, 10'h000);
        idle(10);

        // 6: clear, then a 3-cycle glitch on every bit must be ignored.
        set_sw(10'h000);
        push("t6_clear", cyc + LAT, 10'h000, 10'h000, 10'h08E);
        idle(10);
        set_sw('1);
        repeat (2) begin
            @(negedge clk);
            chk("t6_glitch_db", int'(db_out), 0);
        end
        set_sw(10'h000);
        repeat (8) begin
            @(negedge clk);
            chk("t6_after_db",   int'(db_out),     0);
            chk("t6_after_rise", int'(rise_pulse), 0);
            chk("t6_after_fall", int'(fall_pulse), 0);
        end

        // Boundary: a pulse of exactly STABLE_CYCLES cycles does get through.
        set_sw(10'h001);
        push("b_rise", cyc + LAT, 10'h001, 10'h001, 10'h000);
        idle(3);
        set_sw(10'h000);
        push("b_fall", cyc + LAT, 10'h000, 10'h000, 10'h001);
        idle(12);

        // Every expected event must have been seen within its window.
        chk("sb_pending", sb.size(), 0);
        foreach (sb[k]) $display("FAIL missing_event %s: got none expected at edge %0d", sb[k].name, sb[k].at);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
